// File: rtl/wasm_core_pkg.sv
// Shared types for the wasmachine execution core: type codes, opcodes,
// trap codes, stack-operation encoding and the LEB128 immediate decoder.
package wasm_types;

    localparam int ENTRY_W = 66;

    localparam logic [1:0] T_I32 = 2'd0;
    localparam logic [1:0] T_I64 = 2'd1;
    localparam logic [1:0] T_F32 = 2'd2;
    localparam logic [1:0] T_F64 = 2'd3;

    localparam logic [7:0] OP_UNREACHABLE = 8'h00;
    localparam logic [7:0] OP_NOP         = 8'h01;
    localparam logic [7:0] OP_END         = 8'h0B;
    localparam logic [7:0] OP_DROP        = 8'h1A;
    localparam logic [7:0] OP_SELECT      = 8'h1B;
    localparam logic [7:0] OP_LOCAL_GET   = 8'h20;
    localparam logic [7:0] OP_LOCAL_SET   = 8'h21;
    localparam logic [7:0] OP_LOCAL_TEE   = 8'h22;
    localparam logic [7:0] OP_I32_CONST   = 8'h41;
    localparam logic [7:0] OP_I64_CONST   = 8'h42;
    localparam logic [7:0] OP_F32_CONST   = 8'h43;
    localparam logic [7:0] OP_F64_CONST   = 8'h44;
    localparam logic [7:0] OP_I32_EQZ     = 8'h45;
    localparam logic [7:0] OP_I32_EQ      = 8'h46;
    localparam logic [7:0] OP_I32_NE      = 8'h47;
    localparam logic [7:0] OP_I32_LT_S    = 8'h48;
    localparam logic [7:0] OP_I32_LT_U    = 8'h49;
    localparam logic [7:0] OP_I64_EQZ     = 8'h50;
    localparam logic [7:0] OP_I64_EQ      = 8'h51;
    localparam logic [7:0] OP_I64_NE      = 8'h52;
    localparam logic [7:0] OP_I32_ADD     = 8'h6A;
    localparam logic [7:0] OP_I32_SUB     = 8'h6B;
    localparam logic [7:0] OP_I32_AND     = 8'h71;
    localparam logic [7:0] OP_I32_OR      = 8'h72;
    localparam logic [7:0] OP_I32_XOR     = 8'h73;
    localparam logic [7:0] OP_I64_ADD     = 8'h7C;
    localparam logic [7:0] OP_I64_SUB     = 8'h7D;
    localparam logic [7:0] OP_I64_AND     = 8'h83;

    localparam logic [2:0] TRAP_NONE      = 3'd0;
    localparam logic [2:0] TRAP_OVERFLOW  = 3'd1;
    localparam logic [2:0] TRAP_FETCH     = 3'd2;
    localparam logic [2:0] TRAP_UNREACH   = 3'd3;
    localparam logic [2:0] TRAP_OPCODE    = 3'd4;
    localparam logic [2:0] TRAP_TYPE      = 3'd5;
    localparam logic [2:0] TRAP_UNDERFLOW = 3'd6;
    localparam logic [2:0] TRAP_INDEX     = 3'd7;

    typedef enum logic [2:0] {
        SOP_NONE         = 3'd0,
        SOP_PUSH         = 3'd1,
        SOP_POP          = 3'd2,
        SOP_REPLACE      = 3'd3,
        SOP_POP_REPLACE  = 3'd4,
        SOP_POP2_REPLACE = 3'd5
    } stack_op_e;

    typedef struct packed {
        logic [63:0] value;
        logic [3:0]  len;
    } leb_t;

    // LEB128 decoder over the ten immediate bytes (byte 1 in [79:72]).
    // A run with no terminating byte reports the full ten-byte length.
    function automatic leb_t unpack_i64(input logic [79:0] bytes, input logic sign_ext);
        leb_t       r;
        logic       done;
        logic [7:0] b;
        r.value = 64'd0;
        r.len   = 4'd10;
        done    = 1'b0;
        for (int k = 0; k < 10; k++) begin
            b = bytes[79 - 8*k -: 8];
            if (!done) begin
                r.value = r.value | ({57'd0, b[6:0]} << (7*k));
                if (!b[7]) begin
                    done  = 1'b1;
                    r.len = 4'(k + 1);
                    if (sign_ext && b[6] && (k < 9)) begin
                        r.value = r.value | (64'hFFFF_FFFF_FFFF_FFFF << (7*(k + 1)));
                    end else begin
                        r.value = r.value;
                    end
                end else begin
                    done = 1'b0;
                end
            end else begin
                done = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wasm_core_if.sv
// Instruction-memory fetch bus: the core drives the window address, the
// memory answers with an 11-byte window and an end-of-memory flag.
interface wasm_core_if #(
    parameter int ROM_ADDR = 8
);
    logic [ROM_ADDR-1:0] imem_addr;
    logic [87:0]         imem_data;
    logic                imem_error;

    modport master (output imem_addr, input imem_data, input imem_error);
    modport slave  (input imem_addr, output imem_data, output imem_error);
endinterface

// File: rtl/wasm_core_typed_stack.sv
// Register-file operand stack with combinational access to the top three
// entries and a single-cycle push/pop/replace operation.
module typed_stack
    import wasm_types::*;
#(
    parameter int WIDTH = 66,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  stack_op_e                op,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         tos,
    output logic [WIDTH-1:0]         nos,
    output logic [WIDTH-1:0]         third,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    idx1_s;
    logic [CW-1:0]    idx2_s;
    logic [CW-1:0]    idx3_s;

    assign idx1_s = count_r - CW'(1);
    assign idx2_s = count_r - CW'(2);
    assign idx3_s = count_r - CW'(3);
    assign count  = count_r;

    // Top-of-stack read ports; empty slots read as zero.
    always_comb begin
        if (count_r >= CW'(1)) tos = mem_r[idx1_s[PW-1:0]];
        else                   tos = '0;
        if (count_r >= CW'(2)) nos = mem_r[idx2_s[PW-1:0]];
        else                   nos = '0;
        if (count_r >= CW'(3)) third = mem_r[idx3_s[PW-1:0]];
        else                   third = '0;
    end

    // Apply the requested stack operation; the core guarantees legality.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else begin
            case (op)
                SOP_PUSH: begin
                    mem_r[count_r[PW-1:0]] <= wdata;
                    count_r                <= count_r + CW'(1);
                end
                SOP_POP:     count_r <= idx1_s;
                SOP_REPLACE: mem_r[idx1_s[PW-1:0]] <= wdata;
                SOP_POP_REPLACE: begin
                    mem_r[idx2_s[PW-1:0]] <= wdata;
                    count_r               <= idx1_s;
                end
                SOP_POP2_REPLACE: begin
                    mem_r[idx3_s[PW-1:0]] <= wdata;
                    count_r               <= idx2_s;
                end
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/wasm_core.sv
// Three-cycle (FETCH/WAIT/EXEC) WebAssembly stack core with typed operand
// stack, local-variable file, sticky traps and a latched halt on `end`.
module wasm_core
    import wasm_types::*;
#(
    parameter int ROM_ADDR    = 8,
    parameter int STACK_DEPTH = 16,
    parameter int LOCALS      = 4
) (
    input  logic               clk,
    input  logic               reset,
    wasm_core_if.master        bus,
    output logic [63:0]        result,
    output logic [1:0]         result_type,
    output logic               result_empty,
    output logic               halted,
    output logic [2:0]         trap
);
    localparam int CW = $clog2(STACK_DEPTH) + 1;
    localparam int LW = (LOCALS > 1) ? $clog2(LOCALS) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(STACK_DEPTH);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_IDLE  = 2'd3;

    logic [1:0]          state_r;
    logic [ROM_ADDR-1:0] pc_r, imem_addr_r;
    logic [63:0]         result_r;
    logic [1:0]          result_type_r;
    logic                result_empty_r, halted_r;
    logic [2:0]          trap_r;
    logic [ENTRY_W-1:0]  locals_r [LOCALS];

    logic [7:0]          opcode_s;
    logic [79:0]         imm_s;
    leb_t                leb_s;
    logic [ENTRY_W-1:0]  tos_s, nos_s, third_s, wdata_s;
    logic [CW-1:0]       cnt_s;
    stack_op_e           op_s, stk_op_s;
    logic [2:0]          trap_s;
    logic [3:0]          imm_len_s;
    logic                loc_we_s, is_end_s, idx_ok_s, exec_ok_s;
    logic [LW-1:0]       loc_idx_s;
    logic [63:0]         alu32_s, alu64_s;

    assign opcode_s  = bus.imem_data[87:80];
    assign imm_s     = bus.imem_data[79:0];
    assign leb_s     = unpack_i64(imm_s, (opcode_s == OP_I32_CONST) || (opcode_s == OP_I64_CONST));
    assign idx_ok_s  = (leb_s.value < 64'(LOCALS));
    assign loc_idx_s = leb_s.value[LW-1:0];
    assign exec_ok_s = (state_r == ST_EXEC) && !bus.imem_error && (trap_s == TRAP_NONE);
    assign stk_op_s  = exec_ok_s ? op_s : SOP_NONE;

    assign bus.imem_addr = imem_addr_r;
    assign result        = result_r;
    assign result_type   = result_type_r;
    assign result_empty  = result_empty_r;
    assign halted        = halted_r;
    assign trap          = trap_r;

    typed_stack #(.WIDTH(ENTRY_W), .DEPTH(STACK_DEPTH)) u_stack (
        .clk   (clk),
        .reset (reset),
        .op    (stk_op_s),
        .wdata (wdata_s),
        .tos   (tos_s),
        .nos   (nos_s),
        .third (third_s),
        .count (cnt_s)
    );

    // Binary-op results: lhs is the entry below TOS, rhs is TOS.
    always_comb begin
        alu32_s = 64'd0;
        alu64_s = 64'd0;
        case (opcode_s)
            OP_I32_EQ:   alu32_s = {63'd0, nos_s[31:0] == tos_s[31:0]};
            OP_I32_NE:   alu32_s = {63'd0, nos_s[31:0] != tos_s[31:0]};
            OP_I32_LT_S: alu32_s = {63'd0, $signed(nos_s[31:0]) < $signed(tos_s[31:0])};
            OP_I32_LT_U: alu32_s = {63'd0, nos_s[31:0] < tos_s[31:0]};
            OP_I32_ADD:  alu32_s = {32'd0, nos_s[31:0] + tos_s[31:0]};
            OP_I32_SUB:  alu32_s = {32'd0, nos_s[31:0] - tos_s[31:0]};
            OP_I32_AND:  alu32_s = {32'd0, nos_s[31:0] & tos_s[31:0]};
            OP_I32_OR:   alu32_s = {32'd0, nos_s[31:0] | tos_s[31:0]};
            OP_I32_XOR:  alu32_s = {32'd0, nos_s[31:0] ^ tos_s[31:0]};
            OP_I64_EQ:   alu64_s = {63'd0, nos_s[63:0] == tos_s[63:0]};
            OP_I64_NE:   alu64_s = {63'd0, nos_s[63:0] != tos_s[63:0]};
            OP_I64_ADD:  alu64_s = nos_s[63:0] + tos_s[63:0];
            OP_I64_SUB:  alu64_s = nos_s[63:0] - tos_s[63:0];
            OP_I64_AND:  alu64_s = nos_s[63:0] & tos_s[63:0];
            default:     alu64_s = 64'd0;
        endcase
    end

    // Decode the fetched window: checks (overflow, underflow, type, index),
    // the stack/local update and the immediate length.
    always_comb begin
        op_s      = SOP_NONE;
        wdata_s   = '0;
        trap_s    = TRAP_NONE;
        loc_we_s  = 1'b0;
        is_end_s  = 1'b0;
        imm_len_s = 4'd0;
        case (opcode_s)
            OP_UNREACHABLE: trap_s = TRAP_UNREACH;
            OP_NOP:         op_s = SOP_NONE;
            OP_END:         is_end_s = 1'b1;
            OP_DROP: begin
                if (cnt_s < CW'(1)) trap_s = TRAP_UNDERFLOW;
                else                op_s = SOP_POP;
            end
            OP_SELECT: begin
                if (cnt_s < CW'(3)) trap_s = TRAP_UNDERFLOW;
                else if ((tos_s[65:64] != T_I32) || (third_s[65:64] != nos_s[65:64])) trap_s = TRAP_TYPE;
                else begin
                    op_s    = SOP_POP2_REPLACE;
                    wdata_s = (tos_s[31:0] != 32'd0) ? third_s : nos_s;
                end
            end
            OP_LOCAL_GET: begin
                imm_len_s = leb_s.len;
                if (cnt_s == CNT_FULL) trap_s = TRAP_OVERFLOW;
                else if (!idx_ok_s)    trap_s = TRAP_INDEX;
                else begin
                    op_s    = SOP_PUSH;
                    wdata_s = locals_r[loc_idx_s];
                end
            end
            OP_LOCAL_SET, OP_LOCAL_TEE: begin
                imm_len_s = leb_s.len;
                if (cnt_s < CW'(1)) trap_s = TRAP_UNDERFLOW;
                else if (!idx_ok_s) trap_s = TRAP_INDEX;
                else begin
                    loc_we_s = 1'b1;
                    op_s     = (opcode_s == OP_LOCAL_SET) ? SOP_POP : SOP_NONE;
                end
            end
            OP_I32_CONST, OP_I64_CONST, OP_F32_CONST, OP_F64_CONST: begin
                if (opcode_s == OP_I32_CONST) begin
                    imm_len_s = leb_s.len;
                    wdata_s   = {T_I32, 32'd0, leb_s.value[31:0]};
                end else if (opcode_s == OP_I64_CONST) begin
                    imm_len_s = leb_s.len;
                    wdata_s   = {T_I64, leb_s.value};
                end else if (opcode_s == OP_F32_CONST) begin
                    imm_len_s = 4'd4;
                    wdata_s   = {T_F32, 32'd0, imm_s[55:48], imm_s[63:56], imm_s[71:64], imm_s[79:72]};
                end else begin
                    imm_len_s = 4'd8;
                    wdata_s   = {T_F64, imm_s[23:16], imm_s[31:24], imm_s[39:32], imm_s[47:40],
                                 imm_s[55:48], imm_s[63:56], imm_s[71:64], imm_s[79:72]};
                end
                if (cnt_s == CNT_FULL) trap_s = TRAP_OVERFLOW;
                else                   op_s = SOP_PUSH;
            end
            OP_I32_EQZ, OP_I64_EQZ: begin
                if (cnt_s < CW'(1)) trap_s = TRAP_UNDERFLOW;
                else if (tos_s[65:64] != ((opcode_s == OP_I32_EQZ) ? T_I32 : T_I64)) trap_s = TRAP_TYPE;
                else begin
                    op_s    = SOP_REPLACE;
                    wdata_s = (opcode_s == OP_I32_EQZ) ? {T_I32, 63'd0, tos_s[31:0] == 32'd0}
                                                       : {T_I32, 63'd0, tos_s[63:0] == 64'd0};
                end
            end
            OP_I32_EQ, OP_I32_NE, OP_I32_LT_S, OP_I32_LT_U, OP_I32_ADD, OP_I32_SUB,
            OP_I32_AND, OP_I32_OR, OP_I32_XOR: begin
                if (cnt_s < CW'(2)) trap_s = TRAP_UNDERFLOW;
                else if ((tos_s[65:64] != T_I32) || (nos_s[65:64] != T_I32)) trap_s = TRAP_TYPE;
                else begin
                    op_s    = SOP_POP_REPLACE;
                    wdata_s = {T_I32, alu32_s};
                end
            end
            OP_I64_EQ, OP_I64_NE, OP_I64_ADD, OP_I64_SUB, OP_I64_AND: begin
                if (cnt_s < CW'(2)) trap_s = TRAP_UNDERFLOW;
                else if ((tos_s[65:64] != T_I64) || (nos_s[65:64] != T_I64)) trap_s = TRAP_TYPE;
                else begin
                    op_s    = SOP_POP_REPLACE;
                    wdata_s = ((opcode_s == OP_I64_EQ) || (opcode_s == OP_I64_NE)) ? {T_I32, alu64_s}
                                                                                   : {T_I64, alu64_s};
                end
            end
            default: trap_s = TRAP_OPCODE;
        endcase
    end

    // Sequencer: fetch/wait/exec, PC advance, end capture and sticky traps.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_FETCH;
            pc_r           <= '0;
            imem_addr_r    <= '0;
            result_r       <= 64'd0;
            result_type_r  <= 2'd0;
            result_empty_r <= 1'b1;
            halted_r       <= 1'b0;
            trap_r         <= TRAP_NONE;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    imem_addr_r <= pc_r;
                    state_r     <= ST_WAIT;
                end
                ST_WAIT: state_r <= ST_EXEC;
                ST_EXEC: begin
                    if (bus.imem_error) begin
                        trap_r  <= TRAP_FETCH;
                        state_r <= ST_IDLE;
                    end else if (trap_s != TRAP_NONE) begin
                        trap_r  <= trap_s;
                        state_r <= ST_IDLE;
                    end else if (is_end_s) begin
                        pc_r           <= pc_r + ROM_ADDR'(1);
                        halted_r       <= 1'b1;
                        result_empty_r <= (cnt_s == CW'(0));
                        if (cnt_s != CW'(0)) begin
                            result_r      <= tos_s[63:0];
                            result_type_r <= tos_s[65:64];
                        end
                        state_r <= ST_IDLE;
                    end else begin
                        pc_r    <= pc_r + ROM_ADDR'(1) + ROM_ADDR'(imm_len_s);
                        state_r <= ST_FETCH;
                    end
                end
                ST_IDLE: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Local-variable file; every slot resets to an i32 zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LOCALS; i++) locals_r[i] <= {T_I32, 64'd0};
        end else if (exec_ok_s && loc_we_s) begin
            locals_r[loc_idx_s] <= tos_s;
        end
    end
endmodule

// File: tb/tb_wasm_core.sv
// Directed bench for wasm_core: a table of small programs with hand-computed
// final state, plus sequences for cycle count, mid-run reset and fetch error.
module tb_wasm_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] result;
    logic [1:0]  result_type;
    logic        result_empty, halted;
    logic [2:0]  trap;

    int checks = 0;
    int errors = 0;
    int mem_limit = 256;
    logic [7:0] mem [256];

    wasm_core_if #(.ROM_ADDR(8)) bus ();

    wasm_core #(.ROM_ADDR(8), .STACK_DEPTH(16), .LOCALS(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.master),
        .result       (result),
        .result_type  (result_type),
        .result_empty (result_empty),
        .halted       (halted),
        .trap         (trap)
    );

    always #5 clk = ~clk;

    function automatic logic [87:0] window(input logic [7:0] a);
        logic [87:0] w;
        for (int k = 0; k < 11; k++) w[87 - 8*k -: 8] = mem[8'(a + 8'(k))];
        return w;
    endfunction

    // Synchronous instruction ROM with an adjustable end of memory.
    always @(posedge clk) begin
        bus.imem_data  <= window(bus.imem_addr);
        bus.imem_error <= (int'(bus.imem_addr) + 11 > mem_limit);
    end

    typedef struct {
        string        name;
        logic [383:0] prog;
        int           len;
        logic [63:0]  res;
        logic [1:0]   rtype;
        logic         empty;
        logic         halt;
        logic [2:0]   trp;
        int           cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [383:0] prog, input int len);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < len; i++) mem[i] = prog[8*(len - 1 - i) +: 8];
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run(input string name, input int max, output int cyc);
        cyc = 0;
        while (!(halted || (trap != 3'd0)) && (cyc < max)) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= max) chk({name, "_timeout"}, 64'(cyc), 64'(max - 1));
    endtask

    function automatic logic [63:0] cnt_now();
        return 64'(dut.u_stack.count_r);
    endfunction

    task automatic add(input string n, input logic [383:0] p, input int l, input logic [63:0] r,
                       input logic [1:0] t, input logic e, input logic h, input logic [2:0] tr, input int c);
        vec_t v;
        v.name = n; v.prog = p; v.len = l; v.res = r; v.rtype = t;
        v.empty = e; v.halt = h; v.trp = tr; v.cnt = c;
        vecs.push_back(v);
    endtask

    initial begin
        int cyc;
        add("sub",     {8'h41,8'h05,8'h41,8'h03,8'h6B,8'h0B}, 6, 64'd2, 2'd0, 1'b0, 1'b1, 3'd0, 1);
        add("i64add",  {8'h42,8'h7F,8'h42,8'h01,8'h7C,8'h0B}, 6, 64'd0, 2'd1, 1'b0, 1'b1, 3'd0, 1);
        add("i32wrap", {8'h41,8'hFF,8'hFF,8'hFF,8'hFF,8'h07,8'h41,8'h01,8'h6A,8'h0B}, 10,
            64'h0000_0000_8000_0000, 2'd0, 1'b0, 1'b1, 3'd0, 1);
        add("locals",  {8'h41,8'h07,8'h22,8'h02,8'h1A,8'h20,8'h02,8'h20,8'h00,8'h49,8'h0B}, 11,
            64'd0, 2'd0, 1'b0, 1'b1, 3'd0, 1);
        add("lidx",    {8'h41,8'h09,8'h20,8'h04}, 4, 64'd0, 2'd0, 1'b1, 1'b0, 3'd7, 1);
        add("type",    {8'h41,8'h01,8'h42,8'h02,8'h6A}, 5, 64'd0, 2'd0, 1'b1, 1'b0, 3'd5, 2);
        add("under",   {8'h41,8'h01,8'h6A}, 3, 64'd0, 2'd0, 1'b1, 1'b0, 3'd6, 1);
        add("sel0",    {8'h42,8'h0A,8'h42,8'h14,8'h41,8'h00,8'h1B,8'h0B}, 8, 64'd20, 2'd1, 1'b0, 1'b1, 3'd0, 1);
        add("sel1",    {8'h42,8'h0A,8'h42,8'h14,8'h41,8'h01,8'h1B,8'h0B}, 8, 64'd10, 2'd1, 1'b0, 1'b1, 3'd0, 1);
        add("selmix",  {8'h41,8'h0A,8'h42,8'h14,8'h41,8'h01,8'h1B}, 7, 64'd0, 2'd0, 1'b1, 1'b0, 3'd5, 3);
        add("selc",    {8'h41,8'h01,8'h41,8'h02,8'h42,8'h00,8'h1B}, 7, 64'd0, 2'd0, 1'b1, 1'b0, 3'd5, 3);
        add("selund",  {8'h41,8'h01,8'h41,8'h02,8'h1B}, 5, 64'd0, 2'd0, 1'b1, 1'b0, 3'd6, 2);
        add("badop",   {8'hFF}, 1, 64'd0, 2'd0, 1'b1, 1'b0, 3'd4, 0);
        add("unreach", {8'h01,8'h00}, 2, 64'd0, 2'd0, 1'b1, 1'b0, 3'd3, 0);
        add("endempty",{8'h0B}, 1, 64'd0, 2'd0, 1'b1, 1'b1, 3'd0, 0);
        add("dropempty",{8'h1A}, 1, 64'd0, 2'd0, 1'b1, 1'b0, 3'd6, 0);
        add("f64",     {8'h44,8'h18,8'h2D,8'h44,8'h54,8'hFB,8'h21,8'h09,8'h40,8'h0B}, 10,
            64'h4009_21FB_5444_2D18, 2'd3, 1'b0, 1'b1, 3'd0, 1);
        add("f32",     {8'h43,8'hDB,8'h0F,8'h49,8'h40,8'h0B}, 6, 64'h0000_0000_4049_0FDB, 2'd2, 1'b0, 1'b1, 3'd0, 1);
        add("i64ne",   {8'h42,8'h05,8'h42,8'h05,8'h52,8'h0B}, 6, 64'd0, 2'd0, 1'b0, 1'b1, 3'd0, 1);
        add("i64sub",  {8'h42,8'h03,8'h42,8'h05,8'h7D,8'h0B}, 6, 64'hFFFF_FFFF_FFFF_FFFE, 2'd1, 1'b0, 1'b1, 3'd0, 1);
        add("lts",     {8'h41,8'h7F,8'h41,8'h00,8'h48,8'h0B}, 6, 64'd1, 2'd0, 1'b0, 1'b1, 3'd0, 1);
        add("neg",     {8'h41,8'h7F,8'h0B}, 3, 64'h0000_0000_FFFF_FFFF, 2'd0, 1'b0, 1'b1, 3'd0, 1);
        add("xor",     {8'h41,8'h0F,8'h41,8'h3C,8'h73,8'h0B}, 6, 64'h33, 2'd0, 1'b0, 1'b1, 3'd0, 1);
        add("or",      {8'h41,8'h05,8'h41,8'h0A,8'h72,8'h0B}, 6, 64'h0F, 2'd0, 1'b0, 1'b1, 3'd0, 1);
        add("eq",      {8'h41,8'h03,8'h41,8'h03,8'h46,8'h0B}, 6, 64'd1, 2'd0, 1'b0, 1'b1, 3'd0, 1);
        add("and64",   {8'h42,8'hAC,8'h02,8'h21,8'h01,8'h20,8'h01,8'h42,8'hFF,8'h01,8'h83,8'h0B}, 12,
            64'h2C, 2'd1, 1'b0, 1'b1, 3'd0, 1);
        add("eqz",     {8'h41,8'h00,8'h45,8'h0B}, 4, 64'd1, 2'd0, 1'b0, 1'b1, 3'd0, 1);
        add("eqztype", {8'h42,8'h00,8'h45}, 3, 64'd0, 2'd0, 1'b1, 1'b0, 3'd5, 1);
        add("ovf",     {17{8'h41,8'h00}}, 34, 64'd0, 2'd0, 1'b1, 1'b0, 3'd1, 16);
        add("fullbin", {{16{8'h41,8'h01}},8'h6A,8'h0B}, 34, 64'd2, 2'd0, 1'b0, 1'b1, 3'd0, 15);
        add("fulltee", {{16{8'h41,8'h01}},8'h22,8'h00,8'h0B}, 35, 64'd1, 2'd0, 1'b0, 1'b1, 3'd0, 16);
        add("lgetfull",{{16{8'h41,8'h01}},8'h20,8'h00}, 34, 64'd0, 2'd0, 1'b1, 1'b0, 3'd1, 16);

        // Reset state.
        load({8'h0B}, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_result", result, 64'd0);
        chk("rst_type", 64'(result_type), 64'd0);
        chk("rst_empty", 64'(result_empty), 64'd1);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_trap", 64'(trap), 64'd0);
        chk("rst_addr", 64'(bus.imem_addr), 64'd0);

        foreach (vecs[i]) begin
            load(vecs[i].prog, vecs[i].len);
            do_reset();
            run(vecs[i].name, 200, cyc);
            repeat (3) @(negedge clk);
            chk({vecs[i].name, "_trap"},   64'(trap),         64'(vecs[i].trp));
            chk({vecs[i].name, "_halted"}, 64'(halted),       64'(vecs[i].halt));
            chk({vecs[i].name, "_result"}, result,            vecs[i].res);
            chk({vecs[i].name, "_type"},   64'(result_type),  64'(vecs[i].rtype));
            chk({vecs[i].name, "_empty"},  64'(result_empty), 64'(vecs[i].empty));
            chk({vecs[i].name, "_count"},  cnt_now(),         64'(vecs[i].cnt));
        end

        // Four instructions take exactly 12 cycles to halt.
        load({8'h41,8'h05,8'h41,8'h03,8'h6B,8'h0B}, 6);
        do_reset();
        run("latency", 100, cyc);
        chk("latency_cycles", 64'(cyc), 64'd12);

        // Reset in the WAIT state of the third instruction, then re-run.
        do_reset();
        repeat (7) @(negedge clk);
        chk("mid_count", cnt_now(), 64'd2);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_result", result, 64'd0);
        chk("mid_empty", 64'(result_empty), 64'd1);
        chk("mid_halted", 64'(halted), 64'd0);
        chk("mid_trap", 64'(trap), 64'd0);
        chk("mid_addr", 64'(bus.imem_addr), 64'd0);
        chk("mid_count0", cnt_now(), 64'd0);
        reset = 1'b0;
        run("rerun", 100, cyc);
        chk("rerun_cycles", 64'(cyc), 64'd12);
        chk("rerun_result", result, 64'd2);
        chk("rerun_halted", 64'(halted), 64'd1);

        // Fetch window running off the end of a 12-byte memory.
        mem_limit = 12;
        load({8'h01,8'h01,8'h01,8'h01}, 4);
        do_reset();
        run("fetcherr", 100, cyc);
        chk("fetcherr_trap", 64'(trap), 64'd2);
        chk("fetcherr_cycles", 64'(cyc), 64'd9);
        chk("fetcherr_halted", 64'(halted), 64'd0);
        mem_limit = 256;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
